// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: opcodes, functs, ALU encodings
// and legacy enable/zero constants.
package id_stage_pipe_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  // SPECIAL funct field
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;

  // aluop (subtype) encodings
  localparam logic [7:0] EXE_NOP_OP = 8'h00;
  localparam logic [7:0] EXE_AND_OP = 8'h24;
  localparam logic [7:0] EXE_OR_OP  = 8'h25;
  localparam logic [7:0] EXE_XOR_OP = 8'h26;
  localparam logic [7:0] EXE_NOR_OP = 8'h27;
  localparam logic [7:0] EXE_SLL_OP = 8'h7C;
  localparam logic [7:0] EXE_SRL_OP = 8'h02;
  localparam logic [7:0] EXE_SRA_OP = 8'h03;

  // alusel (result type) encodings
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  // Legacy constants; reset is active-low in this pipeline
  localparam logic        RstEnable    = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0;
  localparam logic [4:0]  NOPRegAddr   = 5'b0;
  localparam logic        ReadEnable   = 1'b1;
  localparam logic        ReadDisable  = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  // Map a SPECIAL logic funct to its aluop
  function automatic logic [7:0] logic_funct_op(input logic [5:0] funct);
    case (funct)
      F_AND:   return EXE_AND_OP;
      F_OR:    return EXE_OR_OP;
      F_XOR:   return EXE_XOR_OP;
      default: return EXE_NOR_OP;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// One operand's source select: decoded immediate when the port is not read,
// otherwise $0 / EX bypass / MEM bypass / regfile, in that priority.
module id_fwd_mux
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              re,
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wreg,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] opnd
);

  // A load in EX has no data yet, so it never bypasses; the hazard logic
  // holds the consumer back instead.
  always_comb begin
    opnd = imm;
    if (re == ReadEnable) begin
      if (addr == '0)
        opnd = '0;
      else if (ex_wreg && ex_wd == addr && !ex_is_load)
        opnd = ex_wdata;
      else if (mem_wreg && mem_wd == addr)
        opnd = mem_wdata;
      else
        opnd = rf_data;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS32 ID stage: decodes logic/shift/LUI, reads and forwards operands,
// detects load-use hazards and drives a handshaked ID/EX register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid_i,
  output logic                id_ready_o,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic [31:0]         inst_i,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  input  logic                ex_wreg_i,
  input  logic [REG_AW-1:0]   ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [REG_AW-1:0]   mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                flush_i,
  input  logic                ex_ready_i,
  output logic                ex_valid_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic                stall_req_o
);

  localparam int NUM_RD = 2;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  logic [NUM_RD-1:0]             rd_en;
  logic [NUM_RD-1:0][REG_AW-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_imm;
  logic [NUM_RD-1:0][DATA_W-1:0] rf_data;
  logic [NUM_RD-1:0][DATA_W-1:0] opnd;
  logic [NUM_RD-1:0]             hz;
  logic [ALUOP_W-1:0]            dec_aluop;
  logic [ALUSEL_W-1:0]           dec_alusel;
  logic [REG_AW-1:0]             dec_wd;
  logic                          dec_wreg;
  logic                          adv;

  // Decode: read ports, immediates and destination for the supported subset
  always_comb begin
    rd_en      = '0;
    rd_addr    = '0;
    rd_imm     = '0;
    dec_aluop  = ALUOP_W'(EXE_NOP_OP);
    dec_alusel = ALUSEL_W'(EXE_RES_NOP);
    dec_wd     = REG_AW'(NOPRegAddr);
    dec_wreg   = WriteDisable;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        rd_en[0]   = ReadEnable;
        rd_addr[0] = REG_AW'(rs);
        rd_imm[1]  = DATA_W'(imm16);
        dec_aluop  = (op == OP_ORI)  ? ALUOP_W'(EXE_OR_OP)  :
                     (op == OP_ANDI) ? ALUOP_W'(EXE_AND_OP) : ALUOP_W'(EXE_XOR_OP);
        dec_alusel = ALUSEL_W'(EXE_RES_LOGIC);
        dec_wd     = REG_AW'(rt);
        dec_wreg   = WriteEnable;
      end
      OP_LUI: begin
        rd_imm[0]  = DATA_W'({imm16, 16'h0});
        dec_aluop  = ALUOP_W'(EXE_OR_OP);
        dec_alusel = ALUSEL_W'(EXE_RES_LOGIC);
        dec_wd     = REG_AW'(rt);
        dec_wreg   = WriteEnable;
      end
      OP_SPECIAL: begin
        case (funct)
          F_AND, F_OR, F_XOR, F_NOR: begin
            rd_en      = {ReadEnable, ReadEnable};
            rd_addr[0] = REG_AW'(rs);
            rd_addr[1] = REG_AW'(rt);
            dec_aluop  = ALUOP_W'(logic_funct_op(funct));
            dec_alusel = ALUSEL_W'(EXE_RES_LOGIC);
            dec_wd     = REG_AW'(rd);
            dec_wreg   = WriteEnable;
          end
          F_SLL, F_SRL, F_SRA: begin
            rd_en[1]   = ReadEnable;
            rd_addr[1] = REG_AW'(rt);
            rd_imm[0]  = DATA_W'(sa);
            dec_aluop  = (funct == F_SLL) ? ALUOP_W'(EXE_SLL_OP) :
                         (funct == F_SRL) ? ALUOP_W'(EXE_SRL_OP) : ALUOP_W'(EXE_SRA_OP);
            dec_alusel = ALUSEL_W'(EXE_RES_SHIFT);
            dec_wd     = REG_AW'(rd);
            dec_wreg   = WriteEnable;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign reg1_read_o = rd_en[0];
  assign reg2_read_o = rd_en[1];
  assign reg1_addr_o = rd_addr[0];
  assign reg2_addr_o = rd_addr[1];
  assign rf_data[0]  = reg1_data_i;
  assign rf_data[1]  = reg2_data_i;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
      .re         (rd_en[p]),
      .addr       (rd_addr[p]),
      .imm        (rd_imm[p]),
      .rf_data    (rf_data[p]),
      .ex_wreg    (ex_wreg_i),
      .ex_wd      (ex_wd_i),
      .ex_wdata   (ex_wdata_i),
      .ex_is_load (ex_is_load_i),
      .mem_wreg   (mem_wreg_i),
      .mem_wd     (mem_wd_i),
      .mem_wdata  (mem_wdata_i),
      .opnd       (opnd[p])
    );
    assign hz[p] = rd_en[p] && (rd_addr[p] != '0) && (rd_addr[p] == ex_wd_i);
  end

  assign stall_req_o = if_valid_i && ex_is_load_i && ex_wreg_i && (|hz);
  assign adv         = !ex_valid_o || ex_ready_i;
  assign id_ready_o  = adv && !stall_req_o && !flush_i;

  // ID/EX register: flush > load-use bubble > load > hold under back-pressure
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      ex_valid_o <= 1'b0;
      pc_o       <= '0;
      aluop_o    <= ALUOP_W'(EXE_NOP_OP);
      alusel_o   <= ALUSEL_W'(EXE_RES_NOP);
      reg1_o     <= '0;
      reg2_o     <= '0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (adv && stall_req_o) begin
      ex_valid_o <= 1'b0;
      wreg_o     <= 1'b0;
    end else if (adv) begin
      ex_valid_o <= if_valid_i;
      pc_o       <= pc_i;
      aluop_o    <= dec_aluop;
      alusel_o   <= dec_alusel;
      reg1_o     <= opnd[0];
      reg2_o     <= opnd[1];
      wd_o       <= dec_wd;
      wreg_o     <= if_valid_i && dec_wreg;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: table of decode/forward vectors, hand-written
// hazard/back-pressure/flush/reset sequences, and a randomized run against
// a behavioural reference model.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i, id_ready_o;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush_i, ex_ready_i, ex_valid_o;
  logic [31:0] pc_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o;
  logic [4:0]  wd_o;
  logic        wreg_o, stall_req_o;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .id_ready_o(id_ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o),
    .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        re1, re2;
    logic [4:0]  a1, a2;
    logic [31:0] imm1, imm2;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg;
  } dec_t;

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic [5:0] opc = w[31:26];
    logic [5:0] fn  = w[5:0];
    d = '0;
    if (opc == 6'h0D || opc == 6'h0C || opc == 6'h0E) begin
      d.re1 = 1; d.a1 = w[25:21]; d.imm2 = {16'h0, w[15:0]};
      d.aluop = (opc == 6'h0D) ? 8'h25 : (opc == 6'h0C) ? 8'h24 : 8'h26;
      d.alusel = 3'd1; d.wd = w[20:16]; d.wreg = 1;
    end else if (opc == 6'h0F) begin
      d.imm1 = {w[15:0], 16'h0}; d.aluop = 8'h25; d.alusel = 3'd1;
      d.wd = w[20:16]; d.wreg = 1;
    end else if (opc == 6'h00 && fn >= 6'h24 && fn <= 6'h27) begin
      d.re1 = 1; d.re2 = 1; d.a1 = w[25:21]; d.a2 = w[20:16];
      d.aluop = {2'b00, fn}; d.alusel = 3'd1; d.wd = w[15:11]; d.wreg = 1;
    end else if (opc == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
      d.re2 = 1; d.a2 = w[20:16]; d.imm1 = {27'h0, w[10:6]};
      d.aluop = (fn == 6'h00) ? 8'h7C : {2'b00, fn}; d.alusel = 3'd2;
      d.wd = w[15:11]; d.wreg = 1;
    end
    return d;
  endfunction

  function automatic logic [31:0] ref_opnd(input logic re, input logic [4:0] a,
                                           input logic [31:0] imm, input logic [31:0] rf);
    if (!re) return imm;
    if (a == 0) return 32'h0;
    if (ex_wreg_i && ex_wd_i == a && !ex_is_load_i) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
    return rf;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] inst, rd1, rd2;
    logic        exw;  logic [4:0] exd;  logic [31:0] exdat; logic ld;
    logic        memw; logic [4:0] memd; logic [31:0] memdat;
    logic [7:0]  aluop; logic [2:0] alusel;
    logic [31:0] r1, r2; logic [4:0] wd; logic wreg;
  } vec_t;

  vec_t tbl[10];

  task automatic clear_fwd();
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
  endtask

  logic        m_valid, m_wreg;
  logic [31:0] m_pc, m_r1, m_r2;
  logic [7:0]  m_aluop;
  logic [2:0]  m_alusel;
  logic [4:0]  m_wd;

  initial begin
    dec_t d;
    logic stall_e, adv_e;
    logic [31:0] o1, o2;
    logic [5:0] fnl [7];

    // inst, rd1, rd2, exw, exd, exdat, ld, memw, memd, memdat, aluop, alusel, r1, r2, wd, wreg
    tbl[0] = '{32'h34011100, 32'hDEAD, 32'hBEEF, 0, 0, 0, 0, 0, 0, 0, 8'h25, 3'd1, 32'h0, 32'h1100, 5'd1, 1};
    tbl[1] = '{32'h34220020, 32'hDEAD, 32'hBEEF, 1, 1, 32'h1100, 0, 0, 0, 0, 8'h25, 3'd1, 32'h1100, 32'h20, 5'd2, 1};
    tbl[2] = '{32'h00632024, 32'h1111, 32'h2222, 1, 3, 32'hAAAA, 0, 1, 3, 32'h5555, 8'h24, 3'd1, 32'hAAAA, 32'hAAAA, 5'd4, 1};
    tbl[3] = '{32'h00023025, 32'h99, 32'h77, 0, 0, 0, 0, 1, 0, 32'h1234, 8'h25, 3'd1, 32'h0, 32'h77, 5'd6, 1};
    tbl[4] = '{32'h00031100, 32'h99, 32'h0F, 0, 0, 0, 0, 0, 0, 0, 8'h7C, 3'd2, 32'h4, 32'h0F, 5'd2, 1};
    tbl[5] = '{32'hFC000000, 32'h99, 32'h0F, 1, 1, 32'h5, 0, 0, 0, 0, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 0};
    tbl[6] = '{32'h3C05ABCD, 32'h99, 32'h0F, 0, 0, 0, 0, 0, 0, 0, 8'h25, 3'd1, 32'hABCD0000, 32'h0, 5'd5, 1};
    tbl[7] = '{32'h3867FFFF, 32'h99, 32'h0F, 1, 4, 32'h7, 1, 1, 3, 32'h5555, 8'h26, 3'd1, 32'h5555, 32'hFFFF, 5'd7, 1};
    tbl[8] = '{32'h000947C3, 32'h99, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 8'h03, 3'd2, 32'h1F, 32'h80000000, 5'd8, 1};
    tbl[9] = '{32'h016C5027, 32'h22, 32'h33, 1, 12, 32'h1, 0, 1, 11, 32'h9, 8'h27, 3'd1, 32'h9, 32'h1, 5'd10, 1};
    fnl = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03};

    rst = 0; if_valid_i = 0; pc_i = 0; inst_i = 0; reg1_data_i = 0; reg2_data_i = 0;
    flush_i = 0; ex_ready_i = 1; clear_fwd();

    #12;
    chk("rst_valid", ex_valid_o, 0); chk("rst_pc", pc_o, 0);
    chk("rst_aluop", aluop_o, 0);    chk("rst_alusel", alusel_o, 0);
    chk("rst_reg1", reg1_o, 0);      chk("rst_reg2", reg2_o, 0);
    chk("rst_wd", wd_o, 0);          chk("rst_wreg", wreg_o, 0);
    @(negedge clk) rst = 1;

    // Back-to-back table vectors, one per cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_valid_i = 1; pc_i = 32'h400 + 32'(i) * 4; inst_i = tbl[i].inst;
      reg1_data_i = tbl[i].rd1; reg2_data_i = tbl[i].rd2;
      ex_wreg_i = tbl[i].exw; ex_wd_i = tbl[i].exd; ex_wdata_i = tbl[i].exdat;
      ex_is_load_i = tbl[i].ld;
      mem_wreg_i = tbl[i].memw; mem_wd_i = tbl[i].memd; mem_wdata_i = tbl[i].memdat;
      #1;
      chk($sformatf("t%0d_stall", i), stall_req_o, 0);
      chk($sformatf("t%0d_ready", i), id_ready_o, 1);
      @(posedge clk); #1;
      chk($sformatf("t%0d_valid", i), ex_valid_o, 1);
      chk($sformatf("t%0d_pc", i), pc_o, 32'h400 + 32'(i) * 4);
      chk($sformatf("t%0d_aluop", i), aluop_o, tbl[i].aluop);
      chk($sformatf("t%0d_alusel", i), alusel_o, tbl[i].alusel);
      chk($sformatf("t%0d_reg1", i), reg1_o, tbl[i].r1);
      chk($sformatf("t%0d_reg2", i), reg2_o, tbl[i].r2);
      chk($sformatf("t%0d_wd", i), wd_o, tbl[i].wd);
      chk($sformatf("t%0d_wreg", i), wreg_o, tbl[i].wreg);
    end

    // Load-use: OR $6,$5,$7 behind a load of $5
    @(negedge clk);
    clear_fwd();
    inst_i = 32'h00A73025; pc_i = 32'h500; reg1_data_i = 32'h55; reg2_data_i = 32'h77;
    ex_wreg_i = 1; ex_wd_i = 5; ex_is_load_i = 1;
    #1;
    chk("lu_stall", stall_req_o, 1); chk("lu_ready", id_ready_o, 0);
    chk("lu_addr1", reg1_addr_o, 5); chk("lu_addr2", reg2_addr_o, 7);
    @(posedge clk); #1;
    chk("lu_bubble_valid", ex_valid_o, 0); chk("lu_bubble_wreg", wreg_o, 0);
    @(negedge clk);
    ex_wreg_i = 0; ex_is_load_i = 0;
    #1;
    chk("lu_release_stall", stall_req_o, 0); chk("lu_release_ready", id_ready_o, 1);
    @(posedge clk); #1;
    chk("lu_issue_valid", ex_valid_o, 1); chk("lu_issue_wd", wd_o, 6);
    chk("lu_issue_reg1", reg1_o, 32'h55); chk("lu_issue_reg2", reg2_o, 32'h77);
    chk("lu_issue_pc", pc_o, 32'h500);

    // Back-pressure for 3 cycles, then resume with ORI $9,$0,0x42
    @(negedge clk);
    inst_i = 32'h34090042; pc_i = 32'h504; ex_ready_i = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), id_ready_o, 0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), ex_valid_o, 1);
      chk($sformatf("bp%0d_pc", c), pc_o, 32'h500);
      chk($sformatf("bp%0d_wd", c), wd_o, 6);
      chk($sformatf("bp%0d_reg2", c), reg2_o, 32'h77);
      @(negedge clk);
    end
    ex_ready_i = 1;
    #1;
    chk("bp_resume_ready", id_ready_o, 1);
    @(posedge clk); #1;
    chk("bp_resume_pc", pc_o, 32'h504); chk("bp_resume_reg2", reg2_o, 32'h42);
    chk("bp_resume_wd", wd_o, 9);

    // Flush with SLL $2,$3,4 pending
    @(negedge clk);
    inst_i = 32'h00031100; pc_i = 32'h508; reg2_data_i = 32'hF; flush_i = 1;
    #1;
    chk("fl_ready", id_ready_o, 0);
    @(posedge clk); #1;
    chk("fl_valid", ex_valid_o, 0); chk("fl_pc_hold", pc_o, 32'h504);

    // Reset mid-stream while ex_valid_o=1
    @(negedge clk);
    flush_i = 0;
    @(posedge clk); #1;
    chk("mr_pre_valid", ex_valid_o, 1); chk("mr_pre_reg1", reg1_o, 4);
    #2 rst = 0;
    #1;
    chk("mr_valid", ex_valid_o, 0); chk("mr_pc", pc_o, 0);
    chk("mr_reg1", reg1_o, 0);      chk("mr_reg2", reg2_o, 0);
    chk("mr_wd", wd_o, 0);          chk("mr_wreg", wreg_o, 0);
    chk("mr_aluop", aluop_o, 0);    chk("mr_alusel", alusel_o, 0);
    @(negedge clk) rst = 1;

    // Randomized run against the reference model
    m_valid = 0; m_pc = 0; m_aluop = 0; m_alusel = 0; m_r1 = 0; m_r2 = 0; m_wd = 0; m_wreg = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 9))
        0: inst_i = {6'h0D, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        1: inst_i = {6'h0C, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        2: inst_i = {6'h0E, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        3: inst_i = {6'h0F, 5'($urandom), 5'($urandom_range(0, 7)), 16'($urandom)};
        4, 5, 6, 7: inst_i = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 5'($urandom), fnl[$urandom_range(0, 6)]};
        8: inst_i = {6'h23, 26'($urandom)};
        default: inst_i = $urandom;
      endcase
      pc_i = $urandom; if_valid_i = ($urandom_range(0, 99) < 85);
      ex_ready_i = ($urandom_range(0, 99) < 75); flush_i = ($urandom_range(0, 99) < 5);
      reg1_data_i = $urandom; reg2_data_i = $urandom;
      ex_wreg_i = $urandom_range(0, 1); ex_wd_i = 5'($urandom_range(0, 7));
      ex_wdata_i = $urandom; ex_is_load_i = ($urandom_range(0, 99) < 25);
      mem_wreg_i = $urandom_range(0, 1); mem_wd_i = 5'($urandom_range(0, 7));
      mem_wdata_i = $urandom;
      d = ref_decode(inst_i);
      stall_e = if_valid_i && ex_is_load_i && ex_wreg_i &&
                ((d.re1 && d.a1 != 0 && d.a1 == ex_wd_i) || (d.re2 && d.a2 != 0 && d.a2 == ex_wd_i));
      adv_e = !m_valid || ex_ready_i;
      o1 = ref_opnd(d.re1, d.a1, d.imm1, reg1_data_i);
      o2 = ref_opnd(d.re2, d.a2, d.imm2, reg2_data_i);
      #1;
      chk("rnd_stall", stall_req_o, stall_e);
      chk("rnd_ready", id_ready_o, adv_e && !stall_e && !flush_i);
      chk("rnd_re", {reg1_read_o, reg2_read_o}, {d.re1, d.re2});
      chk("rnd_addr", {reg1_addr_o, reg2_addr_o}, {d.a1, d.a2});
      @(posedge clk);
      if (flush_i) m_valid = 0;
      else if (adv_e && stall_e) begin m_valid = 0; m_wreg = 0; end
      else if (adv_e) begin
        m_valid = if_valid_i; m_pc = pc_i; m_aluop = d.aluop; m_alusel = d.alusel;
        m_r1 = o1; m_r2 = o2; m_wd = d.wd; m_wreg = if_valid_i && d.wreg;
      end
      #1;
      chk("rnd_valid", ex_valid_o, m_valid); chk("rnd_pc", pc_o, m_pc);
      chk("rnd_aluop", aluop_o, m_aluop);    chk("rnd_alusel", alusel_o, m_alusel);
      chk("rnd_reg1", reg1_o, m_r1);         chk("rnd_reg2", reg2_o, m_r2);
      chk("rnd_wd", wd_o, m_wd);             chk("rnd_wreg", wreg_o, m_wreg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised instruction-decode stage for the MIPS32 pipeline; sits between the IF/ID register and EX.
- Decodes the logic, shift and LUI subset, reads rs/rt from regfile with EX/MEM forwarding, detects load-use hazards, and drives a valid/ready-handshaked ID/EX output register.
- Supports flush.

Parameters:
- DATA_W, 32, operand/register data width.
- ADDR_W, 32, instruction address width.
- REG_AW, 5, register-file address width.
- ALUOP_W, 8, aluop encoding width.
- ALUSEL_W, 3, alusel encoding width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- if_valid_i  in  1  IF/ID holds a valid instruction.
- id_ready_o  out  1  ID accepts the current instruction this cycle.
- pc_i  in  ADDR_W  instruction PC.
- inst_i  in  32  instruction word.
- reg1_read_o / reg2_read_o  out  1  regfile read enables (combinational).
- reg1_addr_o / reg2_addr_o  out  REG_AW  regfile read addresses (combinational).
- reg1_data_i / reg2_data_i  in  DATA_W  regfile read data, same cycle.
- ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i  in  1/REG_AW/DATA_W/1  EX-stage writeback info.
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/REG_AW/DATA_W  MEM-stage writeback info.
- flush_i  in  1  kill the ID/EX contents and the current ID instruction.
- ex_ready_i  in  1  EX can accept.
- ex_valid_o  out  1  ID/EX register valid.
- pc_o  out  ADDR_W  registered PC.
- aluop_o / alusel_o  out  ALUOP_W/ALUSEL_W  registered op subtype/type.
- reg1_o / reg2_o  out  DATA_W  registered operands.
- wd_o / wreg_o  out  REG_AW/1  registered destination and write enable.
- stall_req_o  out  1  load-use stall request to the controller.

Behaviour:
- Reset (rst=0, async): ex_valid_o=0, pc_o=0, aluop_o=NOP_OP, alusel_o=RES_NOP, reg1_o=reg2_o=0, wd_o=0, wreg_o=0. Combinational outputs follow the rules below.
- Decode (combinational):
  - ORI/ANDI/XORI (001101/001100/001110): read rs; reg2 = zero-extended imm16; wd=rt; wreg=1.
  - LUI (001111): no reads; reg1 = {imm16, 16'h0} zero-extended to DATA_W; reg2 = 0; aluop OR; wd=rt.
  - SPECIAL (000000), funct AND/OR/XOR/NOR (100100–100111): read rs, rt; wd=rd.
  - SPECIAL, funct SLL/SRL/SRA (000000/000010/000011): read rt only; reg1 = zero-extended sa; reg2 = rt; wd=rd.
  - Any other encoding: aluop NOP, wreg=0, no reads, operands 0; still flows as a valid bubble-op.
  - Unused read address = 0, read enable = 0.
- Operand source, per read port:
  - Address 0 → 0.
  - Else EX match (ex_wreg_i, ex_wd_i==addr, !ex_is_load_i) → ex_wdata_i.
  - Else MEM match → mem_wdata_i.
  - Else regfile data.
  - EX has priority over MEM.
- Load-use hazard: stall_req_o=1 when if_valid_i, ex_is_load_i, ex_wreg_i, and ex_wd_i equals a nonzero address whose read enable is set.
- Advance: adv = !ex_valid_o | ex_ready_i. id_ready_o = adv & !stall_req_o & !flush_i.
- Clock edge:
  - flush_i → ex_valid_o←0, other outputs hold. Flush takes priority over all else.
  - Else adv & stall_req_o → insert bubble: ex_valid_o←0, wreg_o←0.
  - Else adv → load decoded fields; ex_valid_o←if_valid_i.
  - Else (EX back-pressure) → hold all outputs.
- Latency: one cycle from acceptance to ex_valid_o.
- Back-to-back throughput: 1 instruction/cycle when there is no hazard.
- wreg_o is 0 whenever the stage loads a bubble.
- Width: imm zero-extension fills DATA_W-16 upper bits. sa is zero-extended to DATA_W.

Decomposition:
- Shared defines package (defines.v) holds:
  - opcode and funct constants;
  - EXE_*_OP / EXE_RES_* encodings;
  - RstEnable redefined for active-low;
  - ZeroWord;
  - NOPRegAddr;
  - Read/WriteEnable.
- Sub-module id_fwd_mux: one operand's zero/EX/MEM/regfile selection. Instantiated twice.

Test Plan:
- Reset mid-stream: rst=0 while ex_valid_o=1 → all registered outputs 0 immediately (async); ex_valid_o=0.
- ORI $1,$0,0x1100 then ORI $2,$1,0x0020 with EX forwarding $1=0x1100 → second op reg1_o=0x00001100, reg2_o=0x00000020, wd_o=2, back-to-back valid.
- Forward priority: EX and MEM both write $3 (0xAAAA / 0x5555) and AND $4,$3,$3 is decoded → reg1_o=reg2_o=0x0000AAAA. A MEM-only write of $0 is not forwarded: operand stays 0.
- Load-use: ex_is_load_i=1, ex_wd_i=5, and inst is OR $6,$5,$7 → stall_req_o=1, id_ready_o=0, next ex_valid_o=0. Deassert the load → instruction issues the following cycle.
- Back-pressure: ex_ready_i=0 for 3 cycles with ex_valid_o=1 → all outputs held and id_ready_o=0. Resume → next instruction loads.
- Flush with a SLL $2,$3,4 pending → ex_valid_o=0 next cycle. Without flush, the same instruction gives reg1_o=4, alusel=SHIFT, and an invalid opcode gives wreg_o=0 with aluop NOP.
